dm_store_buffer: RTL and testbench

- Posted-write buffer between the single-cycle CPU data port and the data SRAM.
- CPU stores enter a small FIFO and return immediately. The FIFO drains into the SRAM in cycles with no load.
- Loads go combinationally to the SRAM. A load that overlaps a buffered store stalls until that store has drained.
- Stores to the tail entry's word are merged into it byte by byte.

---
 rtl/dm_store_buffer_pkg.sv | 22 ++
 rtl/dm_store_buffer_if.sv | 24 ++
 rtl/dm_store_buffer_sb_fifo.sv | 40 ++++
 rtl/dm_store_buffer.sv | 43 ++++
 tb/tb_dm_store_buffer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dm_store_buffer_pkg.sv
// dm_sb_pkg: widths, entry type and byte-merge helper for the store buffer
package dm_sb_pkg;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int WA_W = ADDR_W - 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef struct packed {
    logic [WA_W-1:0] wa;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } entry_t;
  function automatic entry_t merge(entry_t e, logic [STRB_W-1:0] strb, logic [DATA_W-1:0] data);
    entry_t r;
    r = e;
    for (int i = 0; i < STRB_W; i++) if (strb[i]) r.data[8*i+:8] = data[8*i+:8];
    r.strb = e.strb | strb;
    return r;
  endfunction
endpackage

// File: rtl/dm_store_buffer_if.sv
// dm_store_buffer_if: CPU data port and SRAM port of the store buffer
interface dm_store_buffer_if;
  import dm_sb_pkg::*;
  logic cpu_data_read;
  logic [STRB_W-1:0] cpu_data_write;
  logic [ADDR_W-1:0] cpu_data_addr;
  logic [DATA_W-1:0] cpu_data_in;
  logic [DATA_W-1:0] cpu_data_out;
  logic cpu_stall;
  logic buf_empty;
  logic mem_read;
  logic [STRB_W-1:0] mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_do;
  modport slave(
    input cpu_data_read, cpu_data_write, cpu_data_addr, cpu_data_in, mem_do,
    output cpu_data_out, cpu_stall, buf_empty, mem_read, mem_write, mem_addr, mem_di
  );
  modport master(
    output cpu_data_read, cpu_data_write, cpu_data_addr, cpu_data_in, mem_do,
    input cpu_data_out, cpu_stall, buf_empty, mem_read, mem_write, mem_addr, mem_di
  );
endinterface

// File: rtl/dm_store_buffer_sb_fifo.sv
// sb_fifo: store FIFO with tail-entry merge and per-entry word-address compare
module sb_fifo
  import dm_sb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic merge_en,
  input  logic pop,
  input  entry_t din,
  input  logic [WA_W-1:0] cmp_wa,
  output entry_t head,
  output logic [WA_W-1:0] last_wa,
  output logic [CNT_W-1:0] count,
  output logic [DEPTH-1:0] hit
);
  entry_t mem [DEPTH];
  logic [PTR_W-1:0] hd, tl, lt;
  assign lt = tl - PTR_W'(1);
  assign head = mem[hd];
  assign last_wa = mem[lt].wa;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PTR_W-1:0] off;
    assign off = PTR_W'(i) - hd;
    assign hit[i] = ({1'b0, off} < count) && (mem[i].wa == cmp_wa);
  end
  always_ff @(posedge clk) begin
    if (merge_en) mem[lt] <= merge(mem[lt], din.strb, din.data);
    if (push) mem[tl] <= din;
    if (rst) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
    end else begin
      hd <= hd + PTR_W'(pop);
      tl <= tl + PTR_W'(push);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write buffer between the CPU data port and the data SRAM
module dm_store_buffer
  import dm_sb_pkg::*;
(
  input logic clk,
  input logic rst,
  dm_store_buffer_if.slave bus
);
  entry_t head, req;
  logic [WA_W-1:0] wa, last_wa;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] hit;
  logic store, load, mem_rd, drain, coalesce, full, push;
  assign wa = bus.cpu_data_addr[ADDR_W-1:2];
  assign req = '{wa: wa, data: bus.cpu_data_in, strb: bus.cpu_data_write};
  assign store = |bus.cpu_data_write;
  assign load = bus.cpu_data_read && !store;
  assign mem_rd = load && !(|hit);
  assign drain = (count != '0) && !mem_rd;
  assign coalesce = store && (count > CNT_W'(1)) && (last_wa == wa);
  assign full = count == CNT_W'(DEPTH);
  assign push = store && !coalesce && !full;
  assign bus.cpu_stall = (load && |hit) || (store && !coalesce && full);
  assign bus.buf_empty = count == '0;
  assign bus.mem_read = mem_rd;
  assign bus.mem_write = drain ? head.strb : '0;
  assign bus.mem_addr = mem_rd ? bus.cpu_data_addr : drain ? {head.wa, 2'b00} : '0;
  assign bus.mem_di = drain ? head.data : '0;
  assign bus.cpu_data_out = bus.mem_do;
  sb_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .merge_en(coalesce),
    .pop(drain),
    .din(req),
    .cmp_wa(wa),
    .head(head),
    .last_wa(last_wa),
    .count(count),
    .hit(hit)
  );
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed vectors checked against a queue-based model of the buffer
module tb_dm_store_buffer;
  import dm_sb_pkg::*;
  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0] strb;
  } ent_t;
  typedef struct {
    logic mrd;
    logic drain;
    logic coal;
    logic push;
    logic stall;
  } pred_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  always #5 clk = ~clk;
  dm_store_buffer_if ifc();
  dm_store_buffer dut(.clk(clk), .rst(rst), .bus(ifc.slave));
  logic [31:0] sram [1024];
  logic [31:0] ref_mem [1024];
  ent_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  assign ifc.mem_do = sram[ifc.mem_addr[11:2]];
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ifc.mem_write[b]) sram[ifc.mem_addr[11:2]][8*b+:8] <= ifc.mem_di[8*b+:8];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic pred_t predict();
    pred_t p;
    logic st, ld, hit;
    logic [29:0] wa;
    wa = ifc.cpu_data_addr[31:2];
    st = |ifc.cpu_data_write;
    ld = ifc.cpu_data_read && !st;
    hit = 1'b0;
    foreach (q[i]) if (q[i].wa == wa) hit = 1'b1;
    p.mrd = ld && !hit;
    p.drain = (q.size() > 0) && !p.mrd;
    p.coal = st && (q.size() > 1) && (q[q.size()-1].wa == wa);
    p.push = st && !p.coal && (q.size() < DEPTH);
    p.stall = (ld && hit) || (st && !p.coal && (q.size() == DEPTH));
    return p;
  endfunction
  task automatic update();
    pred_t p;
    ent_t e;
    p = predict();
    if (p.drain)
      for (int b = 0; b < 4; b++)
        if (q[0].strb[b]) ref_mem[q[0].wa[9:0]][8*b+:8] = q[0].data[8*b+:8];
    if (rst) q.delete();
    else begin
      if (p.coal) begin
        e = q[q.size()-1];
        for (int b = 0; b < 4; b++)
          if (ifc.cpu_data_write[b]) e.data[8*b+:8] = ifc.cpu_data_in[8*b+:8];
        e.strb = e.strb | ifc.cpu_data_write;
        q[q.size()-1] = e;
      end
      if (p.drain) void'(q.pop_front());
      if (p.push) begin
        e.wa = ifc.cpu_data_addr[31:2];
        e.data = ifc.cpu_data_in;
        e.strb = ifc.cpu_data_write;
        q.push_back(e);
      end
    end
  endtask
  task automatic compare();
    pred_t p;
    logic [31:0] ea;
    p = predict();
    ea = p.mrd ? ifc.cpu_data_addr : p.drain ? {q[0].wa, 2'b00} : 32'h0;
    chk("stall", 32'(ifc.cpu_stall), 32'(p.stall));
    chk("buf_empty", 32'(ifc.buf_empty), 32'(q.size() == 0));
    chk("mem_read", 32'(ifc.mem_read), 32'(p.mrd));
    chk("mem_write", 32'(ifc.mem_write), 32'(p.drain ? q[0].strb : 4'h0));
    chk("mem_addr", ifc.mem_addr, ea);
    chk("mem_di", ifc.mem_di, p.drain ? q[0].data : 32'h0);
    if (p.mrd) chk("load_data", ifc.cpu_data_out, ref_mem[ifc.cpu_data_addr[11:2]]);
  endtask
  task automatic step(input logic r, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic rs = 1'b0);
    @(posedge clk);
    update();
    @(negedge clk);
    rst = rs;
    ifc.cpu_data_read = r;
    ifc.cpu_data_write = w;
    ifc.cpu_data_addr = a;
    ifc.cpu_data_in = d;
    #1 compare();
  endtask
  initial begin
    ifc.cpu_data_read = 1'b0;
    ifc.cpu_data_write = 4'h0;
    ifc.cpu_data_addr = 32'h0;
    ifc.cpu_data_in = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 init = 1'b0;
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_empty", 32'(ifc.buf_empty), 32'h1);
    chk("rst_stall", 32'(ifc.cpu_stall), 32'h0);
    chk("rst_wr", 32'(ifc.mem_write), 32'h0);
    chk("rst_addr", ifc.mem_addr, 32'h0);
    step(1'b0, 4'hF, 32'h100, 32'hDEADBEEF);
    chk("st_stall", 32'(ifc.cpu_stall), 32'h0);
    chk("st_nowr", 32'(ifc.mem_write), 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("dr_wr", 32'(ifc.mem_write), 32'hF);
    chk("dr_addr", ifc.mem_addr, 32'h100);
    chk("dr_di", ifc.mem_di, 32'hDEADBEEF);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("dr_empty", 32'(ifc.buf_empty), 32'h1);
    step(1'b0, 4'hF, 32'h400, 32'h11223344);
    step(1'b1, 4'h0, 32'h500, 32'h0);
    chk("byp_stall", 32'(ifc.cpu_stall), 32'h0);
    chk("byp_rd", 32'(ifc.mem_read), 32'h1);
    chk("byp_wr", 32'(ifc.mem_write), 32'h0);
    chk("byp_addr", ifc.mem_addr, 32'h500);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("defer_wr", 32'(ifc.mem_write), 32'hF);
    chk("defer_addr", ifc.mem_addr, 32'h400);
    step(1'b0, 4'hF, 32'h300, 32'hCAFEF00D);
    step(1'b1, 4'h0, 32'h300, 32'h0);
    chk("haz_stall", 32'(ifc.cpu_stall), 32'h1);
    chk("haz_rd", 32'(ifc.mem_read), 32'h0);
    chk("haz_wr", 32'(ifc.mem_write), 32'hF);
    step(1'b1, 4'h0, 32'h300, 32'h0);
    chk("haz_go", 32'(ifc.cpu_stall), 32'h0);
    chk("haz_data", ifc.cpu_data_out, 32'hCAFEF00D);
    step(1'b0, 4'hF, 32'h200, 32'h11111111);
    step(1'b0, 4'h1, 32'h200, 32'h000000AA);
    step(1'b0, 4'h4, 32'h202, 32'h00CC0000);
    chk("b0_wr", 32'(ifc.mem_write), 32'h1);
    chk("b0_di", ifc.mem_di, 32'h000000AA);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("b2_wr", 32'(ifc.mem_write), 32'h4);
    chk("b2_addr", ifc.mem_addr, 32'h200);
    chk("b2_di", ifc.mem_di, 32'h00CC0000);
    step(1'b1, 4'h0, 32'h200, 32'h0);
    chk("bytes_data", ifc.cpu_data_out, 32'h11CC11AA);
    step(1'b1, 4'hF, 32'h600, 32'h600D600D);
    chk("rw_rd", 32'(ifc.mem_read), 32'h0);
    chk("rw_stall", 32'(ifc.cpu_stall), 32'h0);
    step(1'b0, 4'hF, 32'h700, 32'h77777777);
    chk("rw_drain", ifc.mem_addr, 32'h600);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("rstdr_wr", 32'(ifc.mem_write), 32'hF);
    chk("rstdr_addr", ifc.mem_addr, 32'h700);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("post_empty", 32'(ifc.buf_empty), 32'h1);
    chk("post_wr", 32'(ifc.mem_write), 32'h0);
    step(1'b1, 4'h0, 32'h700, 32'h0);
    chk("rstwr_data", ifc.cpu_data_out, 32'h77777777);
    step(1'b1, 4'h0, 32'h600, 32'h0);
    chk("rw_data", ifc.cpu_data_out, 32'h600D600D);
    for (int i = 0; i < 24; i++)
      step(i % 3 == 0, (i % 3 == 0) ? 4'h0 : 4'(1 << (i % 4)),
           32'h800 + 32'((i % 4) * 4), 32'(i) * 32'h01010101);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
